// File: rtl/ahb_pixel_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_pixel_fetch
//  Description : AHB-Lite read master that fetches a run of consecutive
//                32-bit words and streams them out through a small FIFO
//                with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_pixel_fetch #(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   // job control
   input  logic             start,
   input  logic [31:0]      base_addr,
   input  logic [CNT_W-1:0] word_count,
   output logic             busy,
   output logic             done,
   // AHB-Lite master
   output logic [31:0]      HADDR,
   output logic [1:0]       HTRANS,
   output logic             HWRITE,
   output logic [2:0]       HSIZE,
   input  logic             HREADY,
   input  logic [31:0]      HRDATA,
   // pixel stream
   output logic [31:0]      pix_data,
   output logic             pix_valid,
   input  logic             pix_ready
);

   localparam int c_AW = $clog2(FIFO_DEPTH);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_FETCH = 2'd1;
   localparam logic [1:0] c_DRAIN = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   localparam logic [1:0]      c_HTRANS_IDLE   = 2'b00;
   localparam logic [1:0]      c_HTRANS_NONSEQ = 2'b10;
   localparam logic [c_AW+1:0] c_DEPTH         = (c_AW+2)'(FIFO_DEPTH);

   logic [1:0]       r_state;
   logic [31:0]      r_addr;
   logic [CNT_W-1:0] r_left;      // address phases still to issue
   logic             r_dphase;    // one data phase outstanding
   logic [31:0]      r_mem [FIFO_DEPTH];
   logic [c_AW-1:0]  r_wptr;
   logic [c_AW-1:0]  r_rptr;
   logic [c_AW:0]    r_count;

   logic             w_room;
   logic             w_nonseq;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   logic             w_valid;
   logic             w_dphase_nxt;
   logic [c_AW:0]    w_count_nxt;

   // Issue only when every word already in flight is guaranteed a FIFO slot,
   // so the FIFO cannot overflow. A pending NONSEQ stays asserted under
   // HREADY=0 because occupancy can only shrink while the bus is stalled.
   assign w_room   = ({1'b0, r_count} + {{(c_AW+1){1'b0}}, r_dphase}) < c_DEPTH;
   assign w_nonseq = (r_state == c_FETCH) && (r_left != '0) && w_room;
   assign w_accept = w_nonseq && HREADY;
   assign w_push   = r_dphase && HREADY;
   assign w_valid  = (r_count != '0);
   assign w_pop    = w_valid && pix_ready;

   // The data phase following an accepted address phase completes only on
   // HREADY; the pipeline advances only when HREADY is high.
   assign w_dphase_nxt = HREADY ? w_accept : r_dphase;

   // Next occupancy, used to leave DRAIN in the same cycle the last word pops
   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + (c_AW+1)'(1);
         2'b01:   w_count_nxt = r_count - (c_AW+1)'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   assign HADDR     = r_addr;
   assign HTRANS    = w_nonseq ? c_HTRANS_NONSEQ : c_HTRANS_IDLE;
   assign HWRITE    = 1'b0;
   assign HSIZE     = 3'b010;
   assign pix_valid = w_valid;
   assign pix_data  = w_valid ? r_mem[r_rptr] : 32'd0;
   assign done      = (r_state == c_DONE);
   // busy rises combinationally with the accepted start so that a zero-length
   // job still shows a single busy cycle before its done pulse.
   assign busy      = (r_state == c_FETCH) || (r_state == c_DRAIN) ||
                      ((r_state == c_IDLE) && start);

   // Job sequencing: capture job parameters, step address and issue count
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state <= c_IDLE;
         r_addr  <= 32'd0;
         r_left  <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  if (word_count != '0) begin
                     r_state <= c_FETCH;
                     r_addr  <= base_addr & 32'hFFFF_FFFC;
                     r_left  <= word_count;
                  end else begin
                     r_state <= c_DONE;
                  end
               end
            end
            c_FETCH: begin
               if (w_accept) begin
                  r_addr <= r_addr + 32'd4;
                  r_left <= r_left - CNT_W'(1);
                  if (r_left == CNT_W'(1)) begin
                     r_state <= c_DRAIN;
                  end
               end
            end
            c_DRAIN: begin
               if (!w_dphase_nxt && (w_count_nxt == '0)) begin
                  r_state <= c_DONE;
               end
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   // Data-phase tracking and FIFO pointers/occupancy
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_dphase <= 1'b0;
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
      end else begin
         r_dphase <= w_dphase_nxt;
         r_count  <= w_count_nxt;
         if (w_push) begin
            r_wptr <= r_wptr + c_AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + c_AW'(1);
         end
      end
   end

   // FIFO storage; contents are never observed while the FIFO is empty
   always_ff @(posedge HCLK) begin
      if (w_push) begin
         r_mem[r_wptr] <= HRDATA;
      end
   end

endmodule
`default_nettype wire

// File: doc/ahb_pixel_fetch.md
AHB_PIXEL_FETCH -- requirements
Module: ahb_pixel_fetch

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, output buffer depth in 32-bit words (power of two, >=2).
REQ-002 Parameter CNT_W, default 16, width of the word-count port.
REQ-003 The clock is HCLK; reset is HRESETn, asynchronous, active-low.
REQ-004 HCLK  input  1  system clock; all state changes on the rising edge.
REQ-005 HRESETn  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to begin a fetch job.
REQ-007 base_addr  input  32  byte address of the first word; sampled on accepted start.
REQ-008 word_count  input  CNT_W  number of 32-bit words to fetch; sampled on accepted start.
REQ-009 busy  output  1  high from accepted start until the done pulse.
REQ-010 done  output  1  one-cycle pulse when the job completes.
REQ-011 HADDR  output  32  AHB-Lite address.
REQ-012 HTRANS  output  2  AHB-Lite transfer type; only IDLE (00) or NONSEQ (10).
REQ-013 HWRITE  output  1  constant 0.
REQ-014 HSIZE  output  3  constant 010 (word).
REQ-015 HREADY  input  1  AHB-Lite transfer-complete signal from the slave.
REQ-016 HRDATA  input  32  AHB-Lite read data.
REQ-017 pix_data  output  32  head-of-FIFO word.
REQ-018 pix_valid  output  1  pix_data holds a valid word.
REQ-019 pix_ready  input  1  consumer accepts; a word transfers on a clock edge where pix_valid and pix_ready are both high.

Function
REQ-020 The FSM SHALL have states IDLE, FETCH, DRAIN and DONE.
- IDLE -> FETCH on start with word_count != 0.
- IDLE -> DONE on start with word_count == 0.
- FETCH -> DRAIN once the last address phase has been accepted (HREADY high).
- DRAIN -> DONE once the last data phase has completed and the FIFO is empty.
- DONE -> IDLE unconditionally after one cycle.
REQ-021 start SHALL be ignored while busy is high.
REQ-022 base_addr[1:0] SHALL be forced to 00; the address SHALL increment by 4 per accepted address phase and wrap modulo 2^32.
REQ-023 In FETCH, HTRANS SHALL be NONSEQ only when (FIFO occupancy + outstanding data phases) < FIFO_DEPTH and words remain to issue; otherwise it SHALL be IDLE.
REQ-024 An address phase SHALL be accepted on an edge with HTRANS=NONSEQ and HREADY=1. HADDR/HTRANS SHALL be held stable while HREADY=0.
REQ-025 The data phase SHALL be the cycle after acceptance. HRDATA SHALL be pushed into the FIFO on the edge at which the data phase sees HREADY=1. At most one data phase SHALL be outstanding.
REQ-026 Latency: start sampled at edge 0 -> NONSEQ driven in cycle 1 -> HRDATA captured at end of cycle 2 (zero-wait slave) -> pix_valid high in cycle 3.
REQ-027 With zero-wait-state HREADY and pix_ready held high, the block SHALL sustain one word per cycle.
REQ-028 A simultaneous FIFO push and pop SHALL keep the occupancy unchanged. The FIFO SHALL never overflow (guaranteed by REQ-023) and SHALL never present an invalid word.
REQ-029 Word order on pix_data SHALL equal ascending address order.
REQ-030 done SHALL pulse in the DONE state; busy SHALL fall in the same cycle done rises.

Reset
REQ-031 On HRESETn low, immediately and regardless of HCLK:
- state = IDLE
- HTRANS = 00, HADDR = 0
- busy = 0, done = 0
- pix_valid = 0, pix_data = 0
- FIFO emptied, counters cleared
REQ-032 A reset asserted mid-job SHALL abort the job; after release, no transfer SHALL occur until a new start.

Verification
REQ-033 Basic fetch: mem[0x100..0x10C] = 0xA0..0xA3, base_addr=0x100, count=4, zero-wait, pix_ready=1 -> pix_data A0,A1,A2,A3 in cycles 3-6; done in cycle 7.
REQ-034 Backpressure: count=8, pix_ready=0 -> exactly 4 NONSEQ issued, then HTRANS=IDLE; raising pix_ready delivers all 8 words in order.
REQ-035 Wait states: HREADY low for 2 cycles during the address phase to 0x104 -> HADDR holds 0x104, no duplicated or lost words.
REQ-036 Zero count: start with count=0 -> no NONSEQ, done pulses at cycle 1, busy high for exactly one cycle.
REQ-037 Wrap: base_addr=0xFFFFFFF8, count=4 -> addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
REQ-038 Reset mid-job: HRESETn low during the 3rd word -> all outputs return to reset values; a new start with base 0x200 fetches from 0x200.
